// File: rtl/adder_pipe_n_if.sv
// Operand/result handshake bundle for the pipelined adder.
// The master side feeds operands and consumes results; the slave side is the adder.
interface adder_pipe_n_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe_n.sv
// Pipelined segmented ripple-carry adder: SEG bits per stage, carry registered between stages.
// Valid/ready handshake; the whole pipeline stalls while a result waits at the output.
module adder_pipe_n #(
  parameter int WIDTH = 8,
  parameter int SEG   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_pipe_n_if.slave  bus
);
  localparam int NSTG = WIDTH / SEG;
  localparam int LAST = NSTG - 1;
  localparam int MSB  = WIDTH - 1;

  // Registers written by stage k; full operands ride along as skew, partial sums as deskew.
  logic [WIDTH-1:0] opa_r   [NSTG];
  logic [WIDTH-1:0] opb_r   [NSTG];
  logic [WIDTH-1:0] sum_r   [NSTG];
  logic [NSTG-1:0]  vld_r;
  logic [NSTG-1:0]  carry_r;
  logic             ovf_r;

  // Inputs seen by stage k: the ports for stage 0, the previous stage registers otherwise.
  logic [WIDTH-1:0] opa_src_s [NSTG];
  logic [WIDTH-1:0] opb_src_s [NSTG];
  logic [WIDTH-1:0] sum_src_s [NSTG];
  logic [WIDTH-1:0] sum_nxt_s [NSTG];
  logic [SEG:0]     seg_s     [NSTG];
  logic [NSTG-1:0]  carry_src_s;
  logic [NSTG-1:0]  vld_src_s;
  logic             ovf_nxt_s;
  logic             advance_s;

  assign advance_s     = !vld_r[LAST] || bus.out_ready;
  assign bus.in_ready  = advance_s;
  assign bus.out_valid = vld_r[LAST];
  assign bus.sum       = sum_r[LAST];
  assign bus.cout      = carry_r[LAST];
  assign bus.ovf       = ovf_r;

  // Per-stage segment addition and merge of the new segment into the travelling sum.
  always_comb begin
    opa_src_s[0]   = bus.a;
    opb_src_s[0]   = bus.b;
    sum_src_s[0]   = {WIDTH{1'b0}};
    carry_src_s[0] = bus.cin;
    vld_src_s[0]   = bus.in_valid;
    for (int k = 1; k < NSTG; k++) begin
      opa_src_s[k]   = opa_r[k-1];
      opb_src_s[k]   = opb_r[k-1];
      sum_src_s[k]   = sum_r[k-1];
      carry_src_s[k] = carry_r[k-1];
      vld_src_s[k]   = vld_r[k-1];
    end
    for (int k = 0; k < NSTG; k++) begin
      seg_s[k] = {1'b0, opa_src_s[k][k*SEG +: SEG]}
               + {1'b0, opb_src_s[k][k*SEG +: SEG]}
               + (SEG+1)'(carry_src_s[k]);
      sum_nxt_s[k] = sum_src_s[k];
      sum_nxt_s[k][k*SEG +: SEG] = seg_s[k][SEG-1:0];
    end
  end

  // Signed overflow needs the sign bits of both operands and of the finished sum.
  always_comb begin
    ovf_nxt_s = 1'b0;
    if ((opa_src_s[LAST][MSB] == opb_src_s[LAST][MSB]) &&
        (sum_nxt_s[LAST][MSB] != opa_src_s[LAST][MSB])) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = 1'b0;
    end
  end

  // Pipeline registers: cleared on reset, shift together on advance, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r   <= {NSTG{1'b0}};
      carry_r <= {NSTG{1'b0}};
      ovf_r   <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        opa_r[k] <= {WIDTH{1'b0}};
        opb_r[k] <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
      end
    end else if (advance_s) begin
      ovf_r <= ovf_nxt_s;
      for (int k = 0; k < NSTG; k++) begin
        vld_r[k]   <= vld_src_s[k];
        carry_r[k] <= seg_s[k][SEG];
        opa_r[k]   <= opa_src_s[k];
        opb_r[k]   <= opb_src_s[k];
        sum_r[k]   <= sum_nxt_s[k];
      end
    end
  end
endmodule

// File: doc/adder_pipe_n.md
# adder_pipe_n

Parametrised, pipelined ripple-carry adder that succeeds the fixed 2-bit structural adder. It splits a WIDTH-bit addition into SEG-bit segments, one per pipeline stage, and registers the carry between stages. It accepts one operand pair per cycle under a valid/ready handshake with full-pipeline backpressure. It also reports carry-out and signed overflow, and serves as the arithmetic core for wider datapaths in the same design.

## Interface
- WIDTH, 8, operand/sum width in bits; must be a multiple of SEG, WIDTH >= SEG.
- SEG, 2, bits added per pipeline stage; stage count NSTG = WIDTH/SEG.
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- in_valid  in  1  operand pair and cin valid this cycle.
- in_ready  out  1  block accepts a pair this cycle.
- a  in  WIDTH  addend, unsigned or two's complement.
- b  in  WIDTH  addend.
- cin  in  1  carry-in into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].

## Operation
- Define advance = !out_valid || out_ready. Drive in_ready = advance (combinational). A transfer occurs when in_valid && in_ready.
- On advance, every stage register shifts one stage forward. Stage 0 captures a, b, cin and in_valid. The valid bit of stage k+1 takes the valid bit of stage k.
- Stage k (0..NSTG-1) adds a[k*SEG +: SEG] + b[k*SEG +: SEG] + carry_k. carry_0 = cin; carry_k for k>0 is the registered carry out of stage k-1. Each stage result is SEG+1 bits: the low SEG bits form the sum segment and the MSB forms the carry.
- Upper operand segments travel through skew registers and reach stage k in step with carry_k. Completed lower sum segments travel through deskew registers so all segments emerge together.
- The final stage produces sum, cout, and ovf. ovf is computed from the operand MSBs carried in the skew registers together with sum[WIDTH-1].
- When !advance (out_valid && !out_ready), all registers hold: no loss, no duplication, outputs stable.
- Bubbles (in_valid=0 on a transfer cycle) propagate as valid=0 slots. Data registers still load on advance; their contents are don't-care while the slot's valid bit is 0.
- Results leave in acceptance order, one per cycle at full throughput.
- NSTG=1 (SEG==WIDTH) degenerates to a single registered adder with latency 1.

## Timing
- Latency: a pair accepted at edge t appears on out_valid/sum/cout/ovf after edge t+NSTG-1, provided no stall intervenes. Each stall cycle adds one cycle of latency.
- Throughput: 1 result/cycle while out_ready=1.
- Reset (rst_n=0, asynchronous): all valid bits, sum, cout, ovf, and every internal data/carry register go to 0 immediately. in_ready=1 while out_valid=0.
- Reset mid-operation: in-flight pairs are discarded. The first out_valid after release belongs to the first pair accepted after release.
- Simultaneous events:
  - in_valid with out_ready=1 while full: accept and emit in the same cycle.
  - out_ready=0 while out_valid=0: in_ready stays 1 and the pipeline keeps filling until a valid result reaches the output.
- Wrap-around: the sum is modulo 2^WIDTH, and the overflowed bit appears only on cout.
- Critical path: one SEG-bit ripple plus a carry register.

## Test plan
- Reset: assert rst_n=0 mid-clock -> out_valid, sum, cout, ovf =0 immediately; in_ready=1; after release, no output until a pair is accepted.
- Single op, WIDTH=8/SEG=2: a=8'hFF, b=8'h01, cin=0 -> exactly 4 cycles later out_valid=1, sum=8'h00, cout=1, ovf=0.
- Signed overflow: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'hFF, cin=0 -> sum=8'h7F, cout=1, ovf=1.
- Streaming: 256 back-to-back pairs a=i, b=255-i, cin=1, out_ready=1 -> each result sum=8'h00, cout=1, ovf=0, one per cycle, in order. Also run the exhaustive 4-bit sweep with WIDTH=4, SEG=1 against a reference model.
- Backpressure: fill the pipeline, then hold out_ready=0 for 3 cycles -> in_ready=0, outputs frozen; on release, all results arrive once each, in order.
- Reset mid-stream: pulse rst_n low with 3 pairs in flight -> none emerge; the next accepted pair a=8'h10, b=8'h20 -> sum=8'h30 after 4 cycles.
